// File: rtl/swcap_bank_ctrl.sv
// swcap_bank_ctrl
// Drives the gate controls of the LC-DCO switched-capacitor array. It accepts
// a fixed-point tuning word over a valid/ready handshake. The integer part
// sets a target cell count, saturated at NCAP. The live count then slews one
// cell per clock toward that target. Once it is locked, an optional
// first-order sigma-delta can add one extra cell to dither the fractional part.
//
// Build option: define SWCAP_DITHER_EN to enable LOCK-state dithering.
// Without it, the fraction field is ignored and sw stays static in LOCK.
//
// Ports
//   clk         clock
//   reset       asynchronous, active-high reset
//   code_in     tuning word: [IW+FW-1:FW] integer cell count, [FW-1:0] fraction
//   code_valid  code_in valid
//   code_ready  code_in can be accepted this cycle (low only while slewing)
//   sw          registered thermometer, bit i drives cell i, LSB-first
//   settled     registered, high once the integer count has reached target
//
// state | meaning
// IDLE  | out of reset, sw all off, no dither
// SLEW  | cur stepping one cell per clock toward tgt, new codes refused
// LOCK  | cur == tgt, optional fractional dither active
module swcap_bank_ctrl #(
    parameter int NCAP = 16,
    parameter int IW   = 5,
    parameter int FW   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW+FW-1:0]  code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic [NCAP-1:0]   sw,
    output logic              settled
);

    typedef enum logic [1:0] {IDLE, SLEW, LOCK} state_t;

    localparam logic [IW-1:0] NCAP_W = IW'(NCAP);

    state_t         state;
    logic [IW-1:0]  cur;
    logic [IW-1:0]  tgt;
    logic [IW-1:0]  code_int;
    logic [IW-1:0]  code_sat;
    logic [IW-1:0]  cur_step;
    logic [IW-1:0]  eff;
    logic           carry;
    logic           xfer;

    assign code_ready = (state != SLEW);
    assign xfer       = code_valid && code_ready;
    assign code_int   = code_in[IW+FW-1:FW];
    assign code_sat   = (code_int > NCAP_W) ? NCAP_W : code_int;
    assign cur_step   = (tgt > cur) ? cur + 1'b1 : cur - 1'b1;

`ifdef SWCAP_DITHER_EN
    logic [FW-1:0]  frac;
    logic [FW-1:0]  acc;
    logic [FW:0]    acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, frac};
    // A carry at full scale would ask for a cell that does not exist.
    assign carry   = acc_sum[FW] && (cur != NCAP_W);
`else
    logic unused_frac;

    assign unused_frac = ^code_in[FW-1:0];
    assign carry       = 1'b0;
`endif

    assign eff = cur + {{(IW-1){1'b0}}, carry};

    function automatic logic [NCAP-1:0] therm(input logic [IW-1:0] n);
        logic [NCAP-1:0] t;
        for (int i = 0; i < NCAP; i++) begin
            t[i] = (i < int'(n));
        end
        return t;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cur     <= '0;
            tgt     <= '0;
            sw      <= '0;
            settled <= 1'b0;
`ifdef SWCAP_DITHER_EN
            frac    <= '0;
            acc     <= '0;
`endif
        end else if (xfer) begin
            // The transfer edge holds the current count. The accumulator
            // restarts, so this edge adds no dither carry.
            tgt <= code_sat;
            sw  <= therm(cur);
`ifdef SWCAP_DITHER_EN
            frac <= code_in[FW-1:0];
            acc  <= '0;
`endif
            if (code_sat == cur) begin
                state   <= LOCK;
                settled <= 1'b1;
            end else begin
                state   <= SLEW;
                settled <= 1'b0;
            end
        end else begin
            case (state)
                SLEW: begin
                    cur <= cur_step;
                    sw  <= therm(cur_step);
                    if (cur_step == tgt) begin
                        state   <= LOCK;
                        settled <= 1'b1;
                    end
                end
                LOCK: begin
`ifdef SWCAP_DITHER_EN
                    acc <= acc_sum[FW-1:0];
`endif
                    sw      <= therm(eff);
                    settled <= 1'b1;
                end
                default: begin
                    sw <= therm(cur);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_swcap_bank_ctrl.sv
module tb_swcap_bank_ctrl;

    localparam int NCAP = 16;
    localparam int IW   = 5;
    localparam int FW   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [IW+FW-1:0]  code_in = '0;
    logic              code_valid = 1'b0;
    logic              code_ready;
    logic [NCAP-1:0]   sw;
    logic              settled;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [NCAP-1:0] sw;
        logic            settled;
        logic            ready;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    swcap_bank_ctrl #(.NCAP(NCAP), .IW(IW), .FW(FW)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .sw         (sw),
        .settled    (settled)
    );

    function automatic logic [NCAP-1:0] ones(input int n);
        logic [NCAP-1:0] v;
        v = '0;
        for (int i = 0; i < NCAP; i++) begin
            if (i < n) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic void push_exp(input logic [NCAP-1:0] s, input logic st, input logic r);
        exp_t e;
        e.sw      = s;
        e.settled = st;
        e.ready   = r;
        sb.push_back(e);
    endfunction

    task automatic drive(input logic v, input int i, input int f);
        code_valid = v;
        code_in    = {IW'(i), FW'(f)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({sw, settled} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: sw=%h settled=%b, expected sw=0 settled=0", sw, settled);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 0, 0);
            push_exp('0, 1'b0, 1'b1);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({sw, settled, code_ready} !== e) begin
                n_fail++;
                $display("FAIL reset_idle edge %0d: sw=%h settled=%b ready=%b, expected sw=%h settled=%b ready=%b",
                         k, sw, settled, code_ready, e.sw, e.settled, e.ready);
            end
        end
    endtask

    task automatic test_idle_zero();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            drive(k == 0, 0, 0);
            push_exp('0, 1'b1, 1'b1);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({sw, settled, code_ready} !== e) begin
                n_fail++;
                $display("FAIL idle_zero edge %0d: sw=%h settled=%b ready=%b, expected sw=%h settled=%b ready=%b",
                         k, sw, settled, code_ready, e.sw, e.settled, e.ready);
            end
        end
    endtask

    task automatic test_up_slew();
        exp_t e;
        drive(1'b1, 5, 0);
        push_exp('0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) push_exp(ones(k), k == 5, k == 5);
        for (int k = 1; k <= 2; k++) push_exp(ones(5), 1'b1, 1'b1);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) drive(k == 2 || k == 3, 9, 0);
            if (k == 6) drive(1'b0, 5, 0);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({sw, settled, code_ready} !== e) begin
                n_fail++;
                $display("FAIL up_slew edge %0d: sw=%h settled=%b ready=%b, expected sw=%h settled=%b ready=%b",
                         k, sw, settled, code_ready, e.sw, e.settled, e.ready);
            end
        end
    endtask

    task automatic test_down_sat();
        exp_t e;
        pulse_reset();
        drive(1'b1, 20, 0);
        push_exp('0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) push_exp(ones(k), k == 16, k == 16);
        for (int k = 0; k < 2; k++) push_exp(ones(16), 1'b1, 1'b1);
        push_exp(ones(16), 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) push_exp(ones(16 - k), k == 6, k == 6);
        for (int k = 0; k < 26; k++) begin
            if (k == 1) drive(1'b0, 20, 0);
            if (k == 19) drive(1'b1, 10, 0);
            if (k == 20) drive(1'b0, 10, 0);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({sw, settled, code_ready} !== e) begin
                n_fail++;
                $display("FAIL down_sat edge %0d: sw=%h settled=%b ready=%b, expected sw=%h settled=%b ready=%b",
                         k, sw, settled, code_ready, e.sw, e.settled, e.ready);
            end
        end
    endtask

    task automatic test_dither();
        exp_t e;
        int   hi;
        int   hi_exp;
        hi = 0;
        drive(1'b1, 5, 0);
        push_exp(ones(10), 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) push_exp(ones(10 - k), k == 5, k == 5);
        push_exp(ones(5), 1'b1, 1'b1);
        for (int k = 1; k <= 64; k++) begin
`ifdef SWCAP_DITHER_EN
            push_exp((k % 4 == 0) ? ones(6) : ones(5), 1'b1, 1'b1);
`else
            push_exp(ones(5), 1'b1, 1'b1);
`endif
        end
        for (int k = 0; k < 71; k++) begin
            if (k == 1) drive(1'b0, 5, 0);
            if (k == 6) drive(1'b1, 5, 4);
            if (k == 7) drive(1'b0, 5, 4);
            step();
            if (k >= 7 && sw === ones(6)) hi++;
            e = sb.pop_front();
            n_checks++;
            if ({sw, settled, code_ready} !== e) begin
                n_fail++;
                $display("FAIL dither edge %0d: sw=%h settled=%b ready=%b, expected sw=%h settled=%b ready=%b",
                         k, sw, settled, code_ready, e.sw, e.settled, e.ready);
            end
        end
`ifdef SWCAP_DITHER_EN
        hi_exp = 16;
`else
        hi_exp = 0;
`endif
        n_checks++;
        if (hi !== hi_exp) begin
            n_fail++;
            $display("FAIL dither_count: %0d edges at 0x003F, expected %0d", hi, hi_exp);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        push_exp(ones(5), 1'b1, 1'b1);
        push_exp(ones(5), 1'b1, 1'b1);
        push_exp(ones(5), 1'b1, 1'b1);
        push_exp(ones(5), 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
`ifdef SWCAP_DITHER_EN
            push_exp((k == 4) ? ones(6) : ones(5), 1'b1, 1'b1);
`else
            push_exp(ones(5), 1'b1, 1'b1);
`endif
        end
        for (int k = 0; k < 8; k++) begin
            drive(k == 0 || k == 3, 5, 4);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({sw, settled, code_ready} !== e) begin
                n_fail++;
                $display("FAIL back_to_back edge %0d: sw=%h settled=%b ready=%b, expected sw=%h settled=%b ready=%b",
                         k, sw, settled, code_ready, e.sw, e.settled, e.ready);
            end
        end
    endtask

    task automatic test_sat_dither();
        exp_t e;
        push_exp(ones(5), 1'b0, 1'b0);
        for (int k = 1; k <= 11; k++) push_exp(ones(5 + k), k == 11, k == 11);
        for (int k = 0; k < 20; k++) push_exp(ones(16), 1'b1, 1'b1);
        for (int k = 0; k < 32; k++) begin
            drive(k == 0, 16, 15);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({sw, settled, code_ready} !== e) begin
                n_fail++;
                $display("FAIL sat_dither edge %0d: sw=%h settled=%b ready=%b, expected sw=%h settled=%b ready=%b",
                         k, sw, settled, code_ready, e.sw, e.settled, e.ready);
            end
        end
    endtask

    task automatic test_reset_mid_slew();
        exp_t e;
        pulse_reset();
        push_exp('0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) push_exp(ones(k), 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            drive(k == 0, 12, 0);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({sw, settled, code_ready} !== e) begin
                n_fail++;
                $display("FAIL mid_slew_ramp edge %0d: sw=%h settled=%b ready=%b, expected sw=%h settled=%b ready=%b",
                         k, sw, settled, code_ready, e.sw, e.settled, e.ready);
            end
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({sw, settled} !== '0) begin
            n_fail++;
            $display("FAIL mid_slew_async: sw=%h settled=%b, expected sw=0 settled=0", sw, settled);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({sw, settled, code_ready} !== {ones(0), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_slew_release: sw=%h settled=%b ready=%b, expected sw=0 settled=0 ready=1",
                     sw, settled, code_ready);
        end
        push_exp('0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) push_exp(ones(k), k == 3, k == 3);
        for (int k = 0; k < 4; k++) begin
            drive(k == 0, 3, 0);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({sw, settled, code_ready} !== e) begin
                n_fail++;
                $display("FAIL mid_slew_restart edge %0d: sw=%h settled=%b ready=%b, expected sw=%h settled=%b ready=%b",
                         k, sw, settled, code_ready, e.sw, e.settled, e.ready);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle_zero();
        test_up_slew();
        test_down_sat();
        test_dither();
        test_back_to_back();
        test_sat_dither();
        test_reset_mid_slew();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
